// File: rtl/maxnet_winner_unit_if.sv
// Result port of the Maxnet winner unit: valid/ready handshake plus the captured result fields.
interface maxnet_winner_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ITER_W = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        winner_idx;
   logic [DATA_W-1:0] winner_val;
   logic [ITER_W-1:0] iter_count;
   logic              timeout;

   modport master (
      output out_valid, winner_idx, winner_val, iter_count, timeout,
      input  out_ready
   );

   modport slave (
      input  out_valid, winner_idx, winner_val, iter_count, timeout,
      output out_ready
   );
endinterface

// File: rtl/maxnet_winner_unit.sv
// Result stage for the 4-neuron Maxnet: counts iterations, captures the single surviving neuron
// on done, or falls back to a signed arg-max when the iteration limit is reached.
module maxnet_winner_unit #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_ITER = 64,
   parameter int unsigned ITER_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  iter_tick,
   input  logic [DATA_W-1:0]     res0,
   input  logic [DATA_W-1:0]     res1,
   input  logic [DATA_W-1:0]     res2,
   input  logic [DATA_W-1:0]     res3,
   input  logic                  done_in,
   maxnet_winner_unit_if.master  out_bus,
   output logic                  busy,
   output logic                  ready_sig
);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   localparam logic [ITER_W:0] Limit = (ITER_W + 1)'(MAX_ITER);

   state_e            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [1:0]        idx_q, idx_d;
   logic [DATA_W-1:0] val_q, val_d;
   logic              timeout_q, timeout_d;
   logic              ready_q, ready_d;

   logic [DATA_W-1:0] res [4];
   logic [3:0]        nz;
   logic              one_hot;
   logic [1:0]        done_idx;
   logic [1:0]        max_idx;
   logic [DATA_W-1:0] max_val;
   logic [ITER_W:0]   iter_plus;
   logic [ITER_W-1:0] iter_sat;
   logic              limit_hit;

   assign res[0] = res0;
   assign res[1] = res1;
   assign res[2] = res2;
   assign res[3] = res3;

   // done_in only counts when exactly one neuron survives; otherwise it is a glitch.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nz[i] = |res[i];
      end
      one_hot = (nz != 4'd0) && ((nz & (nz - 4'd1)) == 4'd0);
      unique case (nz)
         4'b0001: done_idx = 2'd0;
         4'b0010: done_idx = 2'd1;
         4'b0100: done_idx = 2'd2;
         4'b1000: done_idx = 2'd3;
         default: done_idx = 2'd0;
      endcase
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      max_idx = 2'd0;
      max_val = res[0];
      for (int i = 1; i < 4; i++) begin
         if ($signed(res[i]) > $signed(max_val)) begin
            max_idx = 2'(i);
            max_val = res[i];
         end
      end
   end

   assign iter_plus = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
   assign iter_sat  = (&iter_q) ? iter_q : iter_plus[ITER_W-1:0];
   assign limit_hit = iter_tick && (iter_plus == Limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         iter_q    <= '0;
         idx_q     <= '0;
         val_q     <= '0;
         timeout_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         iter_q    <= iter_d;
         idx_q     <= idx_d;
         val_q     <= val_d;
         timeout_q <= timeout_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      iter_d    = iter_q;
      idx_d     = idx_q;
      val_d     = val_q;
      timeout_d = timeout_q;
      ready_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               iter_d    = '0;
               timeout_d = 1'b0;
            end
         end
         StRun: begin
            if (iter_tick) begin
               iter_d = iter_sat;
            end
            if (done_in && one_hot) begin
               state_d   = StHold;
               idx_d     = done_idx;
               val_d     = res[done_idx];
               timeout_d = 1'b0;
            end else if (limit_hit) begin
               state_d   = StHold;
               idx_d     = max_idx;
               val_d     = max_val;
               timeout_d = 1'b1;
            end
         end
         StHold: begin
            if (out_bus.out_ready) begin
               state_d = StIdle;
               ready_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      out_bus.out_valid  = (state_q == StHold);
      out_bus.winner_idx = idx_q;
      out_bus.winner_val = val_q;
      out_bus.iter_count = iter_q;
      out_bus.timeout    = timeout_q;
      busy               = (state_q != StIdle);
      ready_sig          = ready_q;
   end

endmodule

// File: tb/tb_maxnet_winner_unit.sv
// Bench for maxnet_winner_unit: two instances (limit 64 and limit 4), scoreboard queues checked
// by monitors at each handshake, plus direct checks of reset, backpressure and ready_sig.
module tb_maxnet_winner_unit;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] val;
      logic [7:0]  iter;
      logic        to;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, tick_a, done_a, busy_a, rdy_a;
   logic        start_b, tick_b, done_b, busy_b, rdy_b;
   logic [31:0] res_a [4];
   logic [31:0] res_b [4];
   exp_t        q_a [$];
   exp_t        q_b [$];
   int          n_pass = 0;
   int          n_total = 0;

   maxnet_winner_unit_if #(.DATA_W(32), .ITER_W(8)) bus_a ();
   maxnet_winner_unit_if #(.DATA_W(32), .ITER_W(8)) bus_b ();

   maxnet_winner_unit #(.DATA_W(32), .MAX_ITER(64), .ITER_W(8)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .iter_tick(tick_a),
      .res0(res_a[0]), .res1(res_a[1]), .res2(res_a[2]), .res3(res_a[3]),
      .done_in(done_a), .out_bus(bus_a.master), .busy(busy_a), .ready_sig(rdy_a)
   );

   maxnet_winner_unit #(.DATA_W(32), .MAX_ITER(4), .ITER_W(8)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .iter_tick(tick_b),
      .res0(res_b[0]), .res1(res_b[1]), .res2(res_b[2]), .res3(res_b[3]),
      .done_in(done_b), .out_bus(bus_b.master), .busy(busy_b), .ready_sig(rdy_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && bus_a.out_valid && bus_a.out_ready) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q_a.pop_front();
            chk("a_winner_idx", 32'(bus_a.winner_idx), 32'(e.idx));
            chk("a_winner_val", bus_a.winner_val, e.val);
            chk("a_iter_count", 32'(bus_a.iter_count), 32'(e.iter));
            chk("a_timeout", 32'(bus_a.timeout), 32'(e.to));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus_b.out_valid && bus_b.out_ready) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = q_b.pop_front();
            chk("b_winner_idx", 32'(bus_b.winner_idx), 32'(e.idx));
            chk("b_winner_val", bus_b.winner_val, e.val);
            chk("b_iter_count", 32'(bus_b.iter_count), 32'(e.iter));
            chk("b_timeout", 32'(bus_b.timeout), 32'(e.to));
         end
      end
   end

   task automatic set_res_a(input logic [31:0] r0, r1, r2, r3);
      res_a[0] = r0; res_a[1] = r1; res_a[2] = r2; res_a[3] = r3;
   endtask

   task automatic set_res_b(input logic [31:0] r0, r1, r2, r3);
      res_b[0] = r0; res_b[1] = r1; res_b[2] = r2; res_b[3] = r3;
   endtask

   task automatic ticks_a(input int n);
      tick_a = 1'b1;
      for (int i = 0; i < n; i++) step();
      tick_a = 1'b0;
   endtask

   task automatic ticks_b(input int n);
      tick_b = 1'b1;
      for (int i = 0; i < n; i++) step();
      tick_b = 1'b0;
   endtask

   task automatic start_pulse_a();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
   endtask

   task automatic start_pulse_b();
      start_b = 1'b1;
      step();
      start_b = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0; tick_a = 1'b0; done_a = 1'b0; bus_a.out_ready = 1'b0;
      start_b = 1'b0; tick_b = 1'b0; done_b = 1'b0; bus_b.out_ready = 1'b0;
      set_res_a(0, 0, 0, 0);
      set_res_b(0, 0, 0, 0);
      step();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_ready_sig", 32'(rdy_a), 32'd0);
      chk("rst_iter_count", 32'(bus_a.iter_count), 32'd0);
      chk("rst_winner_val", bus_a.winner_val, 32'd0);
      chk("rst_timeout_b", 32'(bus_b.timeout), 32'd0);

      // Normal convergence
      bus_a.out_ready = 1'b1;
      start_pulse_a();
      chk("norm_busy_rise", 32'(busy_a), 32'd1);
      ticks_a(5);
      set_res_a(0, 0, 32'h1A, 0);
      done_a = 1'b1;
      q_a.push_back('{idx: 2'd2, val: 32'h1A, iter: 8'd5, to: 1'b0});
      step();
      done_a = 1'b0;
      chk("norm_out_valid", 32'(bus_a.out_valid), 32'd1);
      step();
      chk("norm_ready_sig", 32'(rdy_a), 32'd1);
      chk("norm_valid_drop", 32'(bus_a.out_valid), 32'd0);
      chk("norm_busy_fall", 32'(busy_a), 32'd0);
      step();
      chk("norm_ready_once", 32'(rdy_a), 32'd0);

      // Backpressure: outputs frozen and ticks ignored while HOLD waits
      bus_a.out_ready = 1'b0;
      start_pulse_a();
      ticks_a(3);
      set_res_a(32'h44, 0, 0, 0);
      done_a = 1'b1;
      q_a.push_back('{idx: 2'd0, val: 32'h44, iter: 8'd3, to: 1'b0});
      step();
      done_a = 1'b0;
      tick_a = 1'b1;
      set_res_a(7, 8, 9, 10);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_out_valid", 32'(bus_a.out_valid), 32'd1);
         chk("bp_iter_frozen", 32'(bus_a.iter_count), 32'd3);
         chk("bp_val_stable", bus_a.winner_val, 32'h44);
         chk("bp_no_ready_sig", 32'(rdy_a), 32'd0);
      end
      tick_a = 1'b0;
      bus_a.out_ready = 1'b1;
      step();
      chk("bp_ready_sig", 32'(rdy_a), 32'd1);
      chk("bp_busy_fall", 32'(busy_a), 32'd0);
      step();
      chk("bp_ready_once", 32'(rdy_a), 32'd0);

      // Glitched done and mid-run start are both ignored
      start_pulse_a();
      ticks_a(2);
      set_res_a(1, 2, 0, 0);
      done_a = 1'b1;
      step();
      done_a = 1'b0;
      chk("glitch_no_valid", 32'(bus_a.out_valid), 32'd0);
      chk("glitch_busy", 32'(busy_a), 32'd1);
      start_pulse_a();
      ticks_a(1);
      set_res_a(0, 32'hFFFF_FFFB, 0, 0);
      done_a = 1'b1;
      q_a.push_back('{idx: 2'd1, val: 32'hFFFF_FFFB, iter: 8'd3, to: 1'b0});
      step();
      done_a = 1'b0;
      step();
      step();

      // Reset while holding a result
      bus_a.out_ready = 1'b0;
      start_pulse_a();
      set_res_a(0, 0, 32'h33, 0);
      done_a = 1'b1;
      step();
      done_a = 1'b0;
      chk("hrst_valid_before", 32'(bus_a.out_valid), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("hrst_out_valid", 32'(bus_a.out_valid), 32'd0);
      chk("hrst_winner_idx", 32'(bus_a.winner_idx), 32'd0);
      chk("hrst_winner_val", bus_a.winner_val, 32'd0);
      chk("hrst_busy", 32'(busy_a), 32'd0);
      chk("hrst_ready_sig", 32'(rdy_a), 32'd0);
      step();
      chk("hrst_no_ready_pulse", 32'(rdy_a), 32'd0);
      chk("hrst_stays_idle", 32'(busy_a), 32'd0);

      // Timeout fallback (limit 4): ties resolve to lowest index
      bus_b.out_ready = 1'b1;
      start_pulse_b();
      ticks_b(3);
      set_res_b(5, 9, 9, 32'hFFFF_FFFD);
      tick_b = 1'b1;
      q_b.push_back('{idx: 2'd1, val: 32'd9, iter: 8'd4, to: 1'b1});
      step();
      tick_b = 1'b0;
      chk("to_out_valid", 32'(bus_b.out_valid), 32'd1);
      step();
      step();

      // Done on the limit-reaching tick wins over timeout
      start_pulse_b();
      ticks_b(3);
      set_res_b(0, 0, 0, 7);
      tick_b = 1'b1;
      done_b = 1'b1;
      q_b.push_back('{idx: 2'd3, val: 32'd7, iter: 8'd4, to: 1'b0});
      step();
      tick_b = 1'b0;
      done_b = 1'b0;
      chk("sim_out_valid", 32'(bus_b.out_valid), 32'd1);
      step();
      step();

      // Every pushed expectation must have been consumed
      for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
      chk("a_queue_drained", 32'(q_a.size()), 32'd0);
      chk("b_queue_drained", 32'(q_b.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/maxnet_winner_unit.md
# maxnet_winner_unit

Downstream result stage for the 4-neuron Maxnet datapath. It tracks iterations of one inference, captures the four neuron outputs when the datapath raises `done`, and encodes the winning neuron index and value. It presents the result on a valid/ready output port, then pulses `ready_sig` back to the datapath to clear `done`. If the net fails to converge within a bounded iteration count, it falls back to an arg-max over the current outputs and flags a timeout.

## Interface
- `DATA_W`, 32, width of each neuron result (two's complement).
- `MAX_ITER`, 64, iteration limit before timeout; range 1..2^ITER_W-1.
- `ITER_W`, 8, width of the iteration counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: a new inference has begun (mem load issued).
- `iter_tick`  in  1  one-cycle pulse per datapath iteration (same pulse as the datapath's `result_signal`).
- `res0`..`res3`  in  DATA_W each  neuron outputs `result[0..3]` from the datapath.
- `done_in`  in  1  datapath `done` (exactly one non-zero result).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `winner_idx`  out  2  index of the winning neuron.
- `winner_val`  out  DATA_W  value of the winning neuron.
- `iter_count`  out  ITER_W  iterations counted for this inference.
- `timeout`  out  1  result came from the arg-max fallback, not from `done_in`.
- `busy`  out  1  high in RUN and HOLD.
- `ready_sig`  out  1  one-cycle pulse to the datapath after handoff, clearing its `done`.

## Operation
- FSM has three states: IDLE, RUN, HOLD.
- **Reset:** state IDLE. All outputs and registers are 0.
- **IDLE**
  - `start`=1 → RUN, `iter_count` cleared to 0, `timeout` cleared.
  - `iter_tick` and `done_in` are ignored.
- **RUN**
  - Each `iter_tick` increments `iter_count`.
  - If `done_in`=1 → capture, go to HOLD.
    - `winner_idx` = position of the single non-zero result.
    - `winner_val` = that result.
    - `timeout`=0.
  - Else if `iter_tick`=1 and `iter_count`+1 == MAX_ITER → timeout capture, go to HOLD.
    - `winner_idx` = arg-max by signed compare over res0..res3; ties go to the lowest index.
    - `winner_val` = that value.
    - `timeout`=1.
  - If `done_in` and the limit-reaching `iter_tick` occur in the same cycle, done capture wins and `timeout`=0. `iter_count` still increments.
  - If `done_in`=1 but two or more results are non-zero (glitch), treat it as not done and stay in RUN.
- **HOLD**
  - `out_valid`=1.
  - `winner_idx`, `winner_val`, `iter_count` and `timeout` stay stable.
  - `iter_tick` is ignored; `iter_count` is frozen.
  - On `out_valid`&`out_ready` → IDLE, with `ready_sig` high for exactly the next cycle.
- `start` in RUN or HOLD is ignored; there is no restart mid-inference.
- `rst` in any state returns to IDLE in one cycle. No `ready_sig` pulse is generated.
- `iter_count` saturates at 2^ITER_W-1 and never wraps.

## Timing
- Capture latency is 1 cycle: `done_in` sampled at edge N gives `out_valid`=1 from cycle N+1.
- Results are sampled on the same edge as `done_in`.
- The handshake completes on the edge where `out_valid`&`out_ready`=1.
  - `out_valid` drops the following cycle.
  - `ready_sig`=1 that following cycle only.
- `out_ready` may be held high permanently. Minimum HOLD dwell is 1 cycle.
- `busy` rises the cycle after `start` and falls the cycle after the handshake.
- `done_in` high in the `start` cycle is ignored. If it is still high in the first RUN cycle, it is captured; this is a stale-done case that upstream must avoid by honouring `ready_sig`.
- Arg-max is combinational from the inputs to the capture registers and sits within one cycle.

## Test plan
- **Normal convergence:** `start`; 5 `iter_tick`s; then res={0,0,0x1A,0} with `done_in`=1 → next cycle `out_valid`=1, `winner_idx`=2, `winner_val`=0x1A, `iter_count`=5, `timeout`=0.
- **Backpressure:** as above with `out_ready`=0 for 10 cycles → outputs are stable and `iter_tick`s are ignored. Raise `out_ready` → `ready_sig` pulses once the next cycle, and `busy` falls.
- **Timeout:** `MAX_ITER`=4, no `done_in`, res={5,9,9,-3} at the 4th tick → `winner_idx`=1, `winner_val`=9, `timeout`=1, `iter_count`=4.
- **Simultaneous:** `MAX_ITER`=4; 4th `iter_tick` in the same cycle as `done_in`, res={0,0,0,7} → `winner_idx`=3, `timeout`=0, `iter_count`=4.
- **Glitch and restart-ignore:** `done_in`=1 with res={1,2,0,0} → stays in RUN. `start` pulse in RUN → `iter_count` is not cleared.
- **Reset mid-HOLD:** assert `rst` for 1 cycle while `out_valid`=1 → next cycle all outputs are 0, state is IDLE, and no `ready_sig` pulse occurs.
